// File: rtl/sr_flag_arbiter.sv
// Round-robin serialiser for SR writes into a shared flag bank.
// Each transaction runs IDLE -> APPLY -> ACK; q, gnt and err are registered.
module sr_flag_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FLAGS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_s,
    input  logic [NUM_REQ-1:0]       req_r,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       err,
    output logic [NUM_FLAGS-1:0]     q,
    output logic [NUM_FLAGS-1:0]     q_bar,
    output logic                     busy
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_win;
    logic                 r_s;
    logic                 r_r;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_FLAGS-1:0] r_q;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_err;

    logic                 w_found;
    logic [PW-1:0]        w_win;
    logic                 w_s;
    logic                 w_r;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_hit;
    logic                 w_bad;
    logic [NUM_FLAGS-1:0] w_q_next;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [PW-1:0]        w_ptr_next;

    // Scan from the pointer upward, wrapping, and take the first request.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = '0;
        w_s     = 1'b0;
        w_r     = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_win   = PW'(j);
                w_s     = req_s[j];
                w_r     = req_r[j];
                w_idx   = req_idx[j*IDX_W +: IDX_W];
            end
        end
    end

    // Illegal SR or an index outside the bank leaves q untouched.
    always_comb begin
        w_hit    = 1'b0;
        w_q_next = r_q;
        for (int f = 0; f < NUM_FLAGS; f++) begin
            if (r_idx == IDX_W'(f)) begin
                w_hit = 1'b1;
                if (r_s && !r_r) w_q_next[f] = 1'b1;
                else if (!r_s && r_r) w_q_next[f] = 1'b0;
            end
        end
        w_bad = (r_s && r_r) || !w_hit;
    end

    assign w_onehot   = NUM_REQ'(1) << r_win;
    assign w_ptr_next = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + PW'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_found) w_next = APPLY;
            APPLY:   w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_idx   <= '0;
            r_q     <= '0;
            r_gnt   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;
            r_gnt   <= '0;
            r_err   <= '0;
            if (r_state == IDLE && w_found) begin
                r_win <= w_win;
                r_s   <= w_s;
                r_r   <= w_r;
                r_idx <= w_idx;
            end
            if (r_state == APPLY) begin
                r_q   <= w_q_next;
                r_gnt <= w_onehot;
                r_err <= w_bad ? w_onehot : '0;
            end
            if (r_state == ACK) r_ptr <= w_ptr_next;
        end
    end

    assign gnt   = r_gnt;
    assign err   = r_err;
    assign q     = r_q;
    assign q_bar = ~r_q;
    assign busy  = (r_state != IDLE);

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shared bank of NUM_FLAGS set/reset flags, written by NUM_REQ independent requesters.
- A round-robin arbiter serialises requests, one at a time.
- Each request carries set/clear bits and a flag index. It is applied with SR semantics: 00 hold, 01 clear, 10 set, 11 illegal.
- Sits between control agents and the status-flag flip-flops; the only writer of the flag bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_FLAGS, 8, number of SR flags in the bank (1..2**IDX_W).
- IDX_W, 3, width of each flag-index field.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held until gnt is seen.
- req_s  input  NUM_REQ  per-requester set bit.
- req_r  input  NUM_REQ  per-requester reset (clear) bit.
- req_idx  input  NUM_REQ*IDX_W  per-requester flag index; requester i uses bits [i*IDX_W +: IDX_W].
- gnt  output  NUM_REQ  one-hot, one-cycle completion pulse (registered).
- err  output  NUM_REQ  one-hot error pulse, coincident with gnt (registered).
- q  output  NUM_FLAGS  flag bank (registered).
- q_bar  output  NUM_FLAGS  bitwise ~q (combinational).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, q=0, gnt=0, err=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Captured payload is cleared.
  - Reset overrides everything, including an in-flight APPLY: no flag update and no gnt.
- State machine (IDLE -> APPLY -> ACK -> IDLE); one transaction takes 3 cycles.
- IDLE:
  - If req != 0, choose the first asserted req at or after pointer, wrapping modulo NUM_REQ.
  - Latch winner, s, r and idx, then go to APPLY.
  - If req == 0, stay in IDLE.
- APPLY, flag update at the end of this cycle:
  - idx >= NUM_FLAGS: no change, error flagged.
  - {s,r}=00: no change (a legal no-op).
  - {s,r}=01: q[idx] <= 0.
  - {s,r}=10: q[idx] <= 1.
  - {s,r}=11: no change, error flagged. Illegal SR is never driven to X.
  - Go to ACK.
- ACK:
  - gnt[winner]=1, and err[winner]=1 if the request was flagged.
  - Pointer <= (winner+1) mod NUM_REQ.
  - Go to IDLE.
- Timing: req sampled in cycle 0 -> q change visible in cycle 2 -> gnt in cycle 2.
- Requester protocol:
  - On the clk edge where the requester samples gnt=1, it drops req or presents a new request.
  - A req still high in the IDLE cycle after ACK is treated as a new request.
- Payload is captured at arbitration. Changes to req_s, req_r, req_idx or req after capture do not affect the transaction in flight.
- req dropped before being captured is simply not served.
- Requests arriving while busy=1 wait; they are not queued beyond the req level.
- Fairness:
  - A requester that keeps req high waits at most NUM_REQ-1 transactions.
  - Pointer wrap: after winner NUM_REQ-1, priority returns to 0.
- Only one flag changes per transaction, and q bits not addressed are never modified.
- gnt and err are 0 in every state except ACK, and at most one bit of each is high.

Test Plan:
- Reset mid-APPLY:
  - Stimulus: reset, then req[1]=1, s=1, r=0, idx=5; assert reset in the APPLY cycle.
  - Response: q stays 0, no gnt, state IDLE and busy=0 next cycle.
- Basic set then clear:
  - Stimulus: req[0] set idx=3; q[3]=1 and q_bar[3]=0 in cycle 2 with gnt=0001. Then req[0] clear idx=3.
  - Response: q=0x00 and gnt=0001 again, err=0 throughout.
- Illegal and out-of-range:
  - Stimulus: with NUM_FLAGS=6 and q=0x05, req[2] with s=r=1 idx=0, then req[2] with s=1 idx=7.
  - Response: q stays 0x05; each transaction gives gnt=0100 and err=0100.
- Round-robin fairness:
  - Stimulus: all four req held high continuously, each setting its own index 0..3.
  - Response: gnt order 0,1,2,3,0; q=0x0F after four transactions; each gnt exactly 3 cycles apart.
- Pointer wrap and priority:
  - Stimulus: after requester 3 wins, assert req[0] and req[2] together.
  - Response: requester 0 wins first, then 2.
  - Stimulus: after requester 1 wins, assert req[0] and req[2] together.
  - Response: requester 2 wins first.
- Payload capture:
  - Stimulus: req[1] set idx=2; change req_idx to 4 and drop req during APPLY.
  - Response: only q[2] set, gnt[1] still pulses, and busy=0 in the following cycle.
